collision_scan_controller: RTL and testbench
============================================

# collision_scan_controller

Sequencer that sweeps the `CollisionChecker` datapath across all 32 target slots of a 160-bit occupancy word and collects the per-target results into one result vector. It captures a scan request, issues one target index per clock to the checker, realigns the registered checker outputs, and reports a collision vector, an any-hit flag and the lowest colliding target. It sits between the host-side request logic and the single shared `CollisionChecker` instance.

## Interface

**Parameters**
- `NUM_TARGETS`, 32: number of target slots scanned.
- `TGT_W`, 5: target index width; equals clog2(`NUM_TARGETS`).
- `DATA_W`, 160: occupancy word width.
- `CHECK_LAT`, 1: checker latency in clocks, from a target issue to a valid `iChkResult`. Legal range 1–4.

**Ports**
- `iClk`, in, 1: the only clock; all logic updates on its rising edge.
- `iReset`, in, 1: synchronous, active-high reset.
- `iStart`, in, 1: scan request; sampled only in IDLE.
- `iData`, in, `DATA_W`: occupancy word; captured on the accepted `iStart`.
- `iTargetMask`, in, `NUM_TARGETS`: enable per target; captured with `iData`.
- `oBusy`, out, 1: high from the accept cycle until `oDone`, inclusive.
- `oDone`, out, 1: one-cycle pulse; the results are valid from this cycle onward.
- `oResult`, out, `NUM_TARGETS`: bit t = checker result for target t. Masked targets read 0.
- `oAnyHit`, out, 1: OR of `oResult`.
- `oFirstHit`, out, `TGT_W`: lowest t with `oResult[t]`=1; 0 if none.
- `oChkTarget`, out, `TGT_W`: drives the checker's `iTarget`.
- `oChkData`, out, `DATA_W`: drives the checker's `iData`; holds the captured word for the whole scan.
- `iChkResult`, in, 1: the checker's `oResult`.

## Operation

- FSM states: IDLE, ISSUE, DRAIN, DONE.
- **IDLE**
  - `iStart`=1 captures `iData`/`iTargetMask`, clears the result registers and sets `oBusy`.
  - If the mask is nonzero, go to ISSUE. If the mask is zero, go directly to DONE with `oResult`=0.
- **ISSUE**
  - One enabled target per cycle, in ascending index order. Masked targets are skipped and take no cycles.
  - Each issue pushes {valid, index} into a `CHECK_LAT`-deep tag pipeline.
  - After the highest enabled target is issued, go to DRAIN.
- **DRAIN**
  - Wait until the tag pipeline is empty, then go to DONE.
- **Result capture** (ISSUE and DRAIN): when the tag at the pipeline tail is valid, write `iChkResult` into `oResult[tag]`. `oFirstHit` updates only on the first hit of the scan.
- **DONE**: pulse `oDone`, drop `oBusy`, return to IDLE.
- `oResult`, `oAnyHit` and `oFirstHit` hold their values until the next accepted `iStart`.
- `iStart` while busy is ignored; it is not queued.
- Reset value of every output is 0. `oChkTarget` reads 0 in IDLE and DONE.
- A reset asserted mid-scan aborts the scan: no `oDone`, results cleared, FSM returns to IDLE.

## Timing

- `iStart` accepted at edge k.
- The first enabled target appears on `oChkTarget` during cycle k+1.
- For N enabled targets (N ≥ 1), the last result is sampled at edge k+N+`CHECK_LAT`. `oDone` is high during cycle k+N+`CHECK_LAT`+1.
- Full mask, `CHECK_LAT`=1: `oDone` 34 cycles after the accept edge.
- Zero mask: `oDone` during cycle k+1.
- Back-to-back scans: the earliest next accept is the cycle after `oDone`.

## Configuration

- Macro `COLLISION_EARLY_EXIT_EN`.
- **Defined**
  - The first captured hit stops issue immediately and moves the FSM to DONE on the next cycle.
  - In-flight tags are discarded.
  - `oResult` contains only the first-hit bit.
  - `oDone` latency becomes (hit issue cycle + `CHECK_LAT` + 1).
- **Undefined**: full scan of all enabled targets, as described above.

## Structure

- Shared package `collision_pkg`:
  - constants `NUM_TARGETS`, `TGT_W`, `DATA_W`;
  - FSM state enum;
  - tag struct {valid, index}.
- One sub-module: `collision_tag_pipe`, the `CHECK_LAT`-deep valid/index shift register with a flush input.
- The `CollisionChecker` instance lives one level up; this block does not instantiate it.

## Test plan

1. Full mask, data 160'h4000…0 (bit 158), `CHECK_LAT`=1 → `oResult`=32'h0000_0001, `oFirstHit`=0, `oAnyHit`=1, `oDone` at k+34.
2. Mask 32'h8000_0001, data with a hit only on target 31 → exactly two issues, `oResult`=32'h8000_0000, `oFirstHit`=31, `oDone` at k+4.
3. Mask 0 → `oDone` during cycle k+1, `oResult`=0, `oChkTarget` never leaves 0.
4. `iStart` re-asserted during ISSUE → ignored, single `oDone`, results unchanged; reset at cycle k+10 → no `oDone`, all outputs 0 next cycle.
5. `CHECK_LAT`=3, full mask, hits on targets 5 and 20 → `oResult`=32'h0010_0020, `oFirstHit`=5, `oDone` at k+36.
6. `COLLISION_EARLY_EXIT_EN` defined, same stimulus as 5 → `oResult`=32'h0000_0020, `oDone` at k+10, no issue beyond target 8.

Source files
------------

// File: rtl/collision_pkg.sv
// Shared types and sizing for the collision scan controller and its tag pipeline.
package collision_pkg;

  localparam int NUM_TARGETS = 32;
  localparam int TGT_W       = 5;
  localparam int DATA_W      = 160;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  typedef struct packed {
    logic             valid;
    logic [TGT_W-1:0] index;
  } tag_t;

endpackage

// File: rtl/collision_tag_pipe.sv
// Delay line carrying {valid, index} tags alongside the checker so results can be
// matched to the target that produced them.
module collision_tag_pipe
  import collision_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  input  tag_t push,
  output tag_t tail,
  output logic upstream_empty
);

  tag_t stages [DEPTH];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        stages[i] <= '0;
      end
    end else begin
      stages[0] <= push;
      for (int i = 1; i < DEPTH; i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign tail = stages[DEPTH-1];

  // High when nothing is in flight except (possibly) the tail entry being consumed now.
  always_comb begin
    upstream_empty = 1'b1;
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (stages[i].valid) begin
        upstream_empty = 1'b0;
      end
    end
  end

endmodule

// File: rtl/collision_scan_controller.sv
// Sweeps the shared CollisionChecker over every enabled target and gathers a result vector.
// Optional feature macro: COLLISION_EARLY_EXIT_EN (stop the scan at the first captured hit).
module collision_scan_controller #(
  parameter int NUM_TARGETS = collision_pkg::NUM_TARGETS,
  parameter int TGT_W       = collision_pkg::TGT_W,
  parameter int DATA_W      = collision_pkg::DATA_W,
  parameter int CHECK_LAT   = 1
) (
  input  logic                   iClk,
  input  logic                   iReset,
  input  logic                   iStart,
  input  logic [DATA_W-1:0]      iData,
  input  logic [NUM_TARGETS-1:0] iTargetMask,
  output logic                   oBusy,
  output logic                   oDone,
  output logic [NUM_TARGETS-1:0] oResult,
  output logic                   oAnyHit,
  output logic [TGT_W-1:0]       oFirstHit,
  output logic [TGT_W-1:0]       oChkTarget,
  output logic [DATA_W-1:0]      oChkData,
  input  logic                   iChkResult
);

  import collision_pkg::*;

  state_t                 state;
  state_t                 next_state;
  logic [NUM_TARGETS-1:0] pending_mask;
  logic [NUM_TARGETS-1:0] remaining_mask;
  logic [NUM_TARGETS-1:0] result_reg;
  logic [DATA_W-1:0]      data_reg;
  logic [TGT_W-1:0]       issue_idx;
  logic [TGT_W-1:0]       first_hit;
  tag_t                   push_tag;
  tag_t                   tail_tag;
  logic                   upstream_empty;
  logic                   accept;
  logic                   capture;
  logic                   capture_hit;
  logic                   flush;

  assign accept      = (state == IDLE) && iStart;
  assign capture     = ((state == ISSUE) || (state == DRAIN)) && tail_tag.valid;
  assign capture_hit = capture && iChkResult;

  // Lowest still-pending target; masked targets never occupy an issue cycle.
  always_comb begin
    issue_idx = '0;
    for (int i = NUM_TARGETS - 1; i >= 0; i--) begin
      if (pending_mask[i]) begin
        issue_idx = TGT_W'(i);
      end
    end
  end

  always_comb begin
    remaining_mask            = pending_mask;
    remaining_mask[issue_idx] = 1'b0;
  end

  always_comb begin
    push_tag       = '0;
    push_tag.valid = (state == ISSUE);
    push_tag.index = issue_idx;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (iStart) begin
          next_state = (iTargetMask == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
`ifdef COLLISION_EARLY_EXIT_EN
        if (capture_hit) begin
          next_state = DONE;
        end else if (remaining_mask == '0) begin
          next_state = DRAIN;
        end
`else
        if (remaining_mask == '0) begin
          next_state = DRAIN;
        end
`endif
      end
      DRAIN: begin
`ifdef COLLISION_EARLY_EXIT_EN
        if (capture_hit || upstream_empty) begin
          next_state = DONE;
        end
`else
        if (upstream_empty) begin
          next_state = DONE;
        end
`endif
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Entering DONE discards anything still in flight (only non-empty on an early exit).
  assign flush = accept || (next_state == DONE);

  always_ff @(posedge iClk) begin
    if (iReset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      pending_mask <= '0;
      data_reg     <= '0;
      result_reg   <= '0;
      first_hit    <= '0;
    end else begin
      if (accept) begin
        pending_mask <= iTargetMask;
        data_reg     <= iData;
        result_reg   <= '0;
        first_hit    <= '0;
      end else if (state == ISSUE) begin
        pending_mask <= remaining_mask;
      end
      if (capture) begin
        result_reg[tail_tag.index] <= iChkResult;
        if (iChkResult && (result_reg == '0)) begin
          first_hit <= tail_tag.index;
        end
      end
    end
  end

  collision_tag_pipe #(
    .DEPTH (CHECK_LAT)
  ) u_tag_pipe (
    .clk            (iClk),
    .reset          (iReset),
    .flush          (flush),
    .push           (push_tag),
    .tail           (tail_tag),
    .upstream_empty (upstream_empty)
  );

  assign oBusy      = (state != IDLE);
  assign oDone      = (state == DONE);
  assign oResult    = result_reg;
  assign oAnyHit    = |result_reg;
  assign oFirstHit  = first_hit;
  assign oChkTarget = (state == ISSUE) ? issue_idx : '0;
  assign oChkData   = data_reg;

endmodule

// File: tb/tb_collision_scan_controller.sv
// Scoreboard bench: two controllers (CHECK_LAT 1 and 3), each driven by a behavioural checker.
module tb_collision_scan_controller;

`ifdef COLLISION_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  typedef struct {
    logic [31:0] result;
    logic [4:0]  first;
    logic        any;
    int          latency;
    logic [4:0]  first_tgt;
    logic [4:0]  max_tgt;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         start    [2];
  logic [159:0] data_in  [2];
  logic [31:0]  mask_in  [2];
  logic         busy     [2];
  logic         done     [2];
  logic [31:0]  res      [2];
  logic         any_hit  [2];
  logic [4:0]   first    [2];
  logic [4:0]   chk_tgt  [2];
  logic [159:0] chk_data [2];
  logic         chk_res  [2];
  logic         c1;
  logic         c3 [3];

  exp_t sb[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  collision_scan_controller #(.CHECK_LAT(1)) dut1 (
    .iClk(clk), .iReset(rst), .iStart(start[0]), .iData(data_in[0]), .iTargetMask(mask_in[0]),
    .oBusy(busy[0]), .oDone(done[0]), .oResult(res[0]), .oAnyHit(any_hit[0]), .oFirstHit(first[0]),
    .oChkTarget(chk_tgt[0]), .oChkData(chk_data[0]), .iChkResult(chk_res[0])
  );

  collision_scan_controller #(.CHECK_LAT(3)) dut3 (
    .iClk(clk), .iReset(rst), .iStart(start[1]), .iData(data_in[1]), .iTargetMask(mask_in[1]),
    .oBusy(busy[1]), .oDone(done[1]), .oResult(res[1]), .oAnyHit(any_hit[1]), .oFirstHit(first[1]),
    .oChkTarget(chk_tgt[1]), .oChkData(chk_data[1]), .iChkResult(chk_res[1])
  );

  // Checker model: slot t occupies bits [(31-t)*5 +: 5]; any set bit is a collision.
  function automatic logic model_hit(input logic [159:0] d, input logic [4:0] t);
    int base;
    base = (31 - int'(t)) * 5;
    return |d[base +: 5];
  endfunction

  always_ff @(posedge clk) begin
    c1    <= model_hit(chk_data[0], chk_tgt[0]);
    c3[0] <= model_hit(chk_data[1], chk_tgt[1]);
    c3[1] <= c3[0];
    c3[2] <= c3[1];
  end

  assign chk_res[0] = c1;
  assign chk_res[1] = c3[2];

  function automatic exp_t build_expect(input int u, input logic [159:0] d, input logic [31:0] m);
    exp_t e;
    int   n;
    int   hit_rank;
    int   lat;
    int   idx [33];
    lat      = (u == 0) ? 1 : 3;
    n        = 0;
    hit_rank = 0;
    e.result    = '0;
    e.first     = '0;
    e.first_tgt = '0;
    e.max_tgt   = '0;
    for (int i = 0; i < 33; i++) idx[i] = 0;
    for (int t = 0; t < 32; t++) begin
      if (m[t]) begin
        n++;
        idx[n] = t;
        if (model_hit(d, 5'(t))) begin
          if (!EARLY) begin
            e.result[t] = 1'b1;
          end else if (hit_rank == 0) begin
            hit_rank    = n;
            e.result[t] = 1'b1;
          end
        end
      end
    end
    for (int t = 31; t >= 0; t--) if (e.result[t]) e.first = 5'(t);
    e.any = |e.result;
    if (n == 0) e.latency = 1;
    else if (EARLY && hit_rank != 0) e.latency = hit_rank + lat + 1;
    else e.latency = n + lat + 1;
    if (n != 0) begin
      e.first_tgt = 5'(idx[1]);
      if (EARLY && hit_rank != 0) e.max_tgt = 5'(idx[(hit_rank + lat < n) ? hit_rank + lat : n]);
      else e.max_tgt = 5'(idx[n]);
    end
    return e;
  endfunction

  task automatic run_scan(input int u, input logic [159:0] d, input logic [31:0] m,
                          input string name, input int restart_at);
    exp_t       e;
    int         c;
    logic       seen_done;
    logic       busy_at_done;
    logic [4:0] max_t;
    logic [4:0] t1;
    sb.push_back(build_expect(u, d, m));
    start[u]   = 1'b1;
    data_in[u] = d;
    mask_in[u] = m;
    @(posedge clk);
    #1 start[u] = 1'b0;
    seen_done    = 1'b0;
    busy_at_done = 1'b0;
    max_t        = '0;
    t1           = '0;
    c            = 0;
    while (!seen_done && c < 200) begin
      @(negedge clk);
      c++;
      if (c == 1) t1 = chk_tgt[u];
      if (chk_tgt[u] > max_t) max_t = chk_tgt[u];
      if (done[u]) begin
        seen_done    = 1'b1;
        busy_at_done = busy[u];
      end
      if (restart_at != 0 && c == restart_at) begin
        start[u]   = 1'b1;
        data_in[u] = ~d;
        mask_in[u] = '1;
      end else begin
        start[u] = 1'b0;
      end
    end
    start[u] = 1'b0;
    e = sb.pop_front();
    tests_run++;
    if (c !== e.latency) begin
      tests_failed++;
      $display("[TB] FAIL %s done latency/timeout: got %0d expected %0d", name, c, e.latency);
    end
    tests_run++;
    if (res[u] !== e.result) begin
      tests_failed++;
      $display("[TB] FAIL %s result: got %h expected %h", name, res[u], e.result);
    end
    tests_run++;
    if (first[u] !== e.first || any_hit[u] !== e.any) begin
      tests_failed++;
      $display("[TB] FAIL %s first/any: got %0d/%b expected %0d/%b", name, first[u], any_hit[u], e.first, e.any);
    end
    tests_run++;
    if (busy_at_done !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL %s busy during done: got %b expected 1", name, busy_at_done);
    end
    tests_run++;
    if (t1 !== e.first_tgt || max_t !== e.max_tgt) begin
      tests_failed++;
      $display("[TB] FAIL %s issue targets first/max: got %0d/%0d expected %0d/%0d", name, t1, max_t, e.first_tgt, e.max_tgt);
    end
    @(negedge clk);
    tests_run++;
    if (done[u] !== 1'b0 || busy[u] !== 1'b0 || res[u] !== e.result) begin
      tests_failed++;
      $display("[TB] FAIL %s after done done/busy/result: got %b/%b/%h expected 0/0/%h", name, done[u], busy[u], res[u], e.result);
    end
  endtask

  task automatic test_reset();
    for (int u = 0; u < 2; u++) begin
      tests_run++;
      if ({done[u], busy[u], any_hit[u], first[u], chk_tgt[u], res[u]} !== '0 || chk_data[u] !== '0) begin
        tests_failed++;
        $display("[TB] FAIL reset outputs u%0d: got done=%b busy=%b res=%h data=%h expected all 0", u, done[u], busy[u], res[u], chk_data[u]);
      end
    end
  endtask

  task automatic test_full_mask();
    logic [159:0] d;
    d = '0;
    d[158] = 1'b1;
    run_scan(0, d, 32'hFFFF_FFFF, "full_mask", 0);
  endtask

  task automatic test_sparse_mask();
    run_scan(0, 160'h1, 32'h8000_0001, "sparse_mask", 0);
  endtask

  task automatic test_zero_mask();
    run_scan(0, {160{1'b1}}, 32'h0, "zero_mask", 0);
  endtask

  task automatic test_restart_ignored();
    logic [159:0] d;
    int extra;
    d = '0;
    d[130] = 1'b1;
    d[12]  = 1'b1;
    run_scan(0, d, 32'h0F0F_F0F0, "restart_ignored", 5);
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done[0]) extra++;
    end
    tests_run++;
    if (extra !== 0) begin
      tests_failed++;
      $display("[TB] FAIL restart queued: got %0d extra done pulses expected 0", extra);
    end
  endtask

  task automatic test_reset_abort();
    int extra;
    start[0]   = 1'b1;
    data_in[0] = {160{1'b1}};
    mask_in[0] = '1;
    @(posedge clk);
    #1 start[0] = 1'b0;
    repeat (10) @(negedge clk);
    tests_run++;
    if (busy[0] !== 1'b1 || res[0] === '0) begin
      tests_failed++;
      $display("[TB] FAIL abort pre-reset busy/result: got %b/%h expected 1/nonzero", busy[0], res[0]);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if ({done[0], busy[0], any_hit[0], first[0], chk_tgt[0], res[0]} !== '0 || chk_data[0] !== '0) begin
      tests_failed++;
      $display("[TB] FAIL abort outputs: got done=%b busy=%b res=%h tgt=%0d expected all 0", done[0], busy[0], res[0], chk_tgt[0]);
    end
    @(negedge clk);
    rst   = 1'b0;
    extra = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done[0]) extra++;
    end
    tests_run++;
    if (extra !== 0) begin
      tests_failed++;
      $display("[TB] FAIL abort done pulses: got %0d expected 0", extra);
    end
  endtask

  task automatic test_lat3();
    logic [159:0] d;
    d = '0;
    d[130] = 1'b1;
    d[55]  = 1'b1;
    run_scan(1, d, 32'hFFFF_FFFF, "lat3_two_hits", 0);
  endtask

  task automatic test_back_to_back();
    run_scan(0, 160'h3 << 40, 32'h0000_FF00, "b2b_first", 0);
    run_scan(0, 160'h1F << 150, 32'h0000_0007, "b2b_second", 0);
  endtask

  task automatic test_random();
    logic [159:0] d;
    for (int i = 0; i < 4; i++) begin
      d = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      d = d & {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      run_scan(i % 2, d, $urandom(), $sformatf("random%0d", i), 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int u = 0; u < 2; u++) begin
      start[u]   = 1'b0;
      data_in[u] = '0;
      mask_in[u] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_full_mask();
    test_sparse_mask();
    test_zero_mask();
    test_restart_ignored();
    test_reset_abort();
    test_lat3();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
